apb_reg_completer: RTL and testbench

// - APB3 completer (responder) owning the DUT address window on the APB bus section; the bench APB initiator drives it.
// - Decodes PADDR against the window, inserts a fixed number of wait states and serves a 32-bit register file.
// - Reports PSLVERR on misaligned accesses; gives the core a write-notify strobe and side ports to read and update registers.

---
 rtl/apb_reg_completer.sv | 152 +++++++++++++++
 tb/tb_apb_reg_completer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_completer.sv
// rtl/apb_reg_completer.sv - APB3 completer serving a 32-bit register file with fixed wait states
module apb_reg_completer #(
    parameter logic [31:0] START_ADDRESS = 32'h8c000000,
    parameter logic [31:0] END_ADDRESS   = 32'h8c0003f8,
    parameter int unsigned WAIT_STATES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        reg_wr,
    output logic [7:0]  reg_widx,
    output logic [31:0] reg_wdata,
    input  logic        core_we,
    input  logic [7:0]  core_idx,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata
);

    localparam int         NREGS     = int'((END_ADDRESS - START_ADDRESS) / 32'd4) + 1;
    localparam logic [7:0] LAST_IDX  = 8'(NREGS - 1);
    localparam logic [4:0] WAIT_LOAD = 5'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state;
    logic [4:0]  wcnt;
    logic        acc_write;
    logic        acc_err;
    logic [7:0]  acc_idx;
    logic [31:0] acc_wdata;
    logic [31:0] acc_rdata;
    logic [31:0] regs [NREGS];

    logic        hit;
    logic        misaligned;
    logic        setup;
    logic        access;
    logic [7:0]  idx;

    // Address decode and APB phase qualifiers
    always_comb begin
        hit        = (PADDR >= START_ADDRESS) && (PADDR <= END_ADDRESS);
        idx        = 8'((PADDR - START_ADDRESS) >> 2);
        misaligned = (PADDR[1:0] != 2'b00);
        setup      = PSEL && !PENABLE;
        access     = PSEL && PENABLE;
    end

    // Core-side read port; indices past the file read as zero
    always_comb begin
        core_rdata = '0;
        if (core_idx <= LAST_IDX) begin
            core_rdata = regs[core_idx];
        end
    end

    // Transfer FSM, register file and registered APB/notify outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            acc_write <= 1'b0;
            acc_err   <= 1'b0;
            acc_idx   <= '0;
            acc_wdata <= '0;
            acc_rdata <= '0;
            PRDATA    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_widx  <= '0;
            reg_wdata <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr <= 1'b0;

            // Core write first so a same-index APB commit below overrides it
            if (core_we && (core_idx <= LAST_IDX)) begin
                regs[core_idx] <= core_wdata;
            end

            case (state)
                IDLE: begin
                    if (setup && hit) begin
                        state     <= ACCESS;
                        acc_write <= PWRITE;
                        acc_idx   <= idx;
                        acc_wdata <= PWDATA;
                        acc_err   <= misaligned;
                        acc_rdata <= regs[idx];
                        if (misaligned) begin
                            // Errors complete on the first access cycle
                            wcnt    <= '0;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                            PRDATA  <= '0;
                        end else begin
                            wcnt    <= WAIT_LOAD;
                            PREADY  <= (WAIT_LOAD == 5'd0);
                            PSLVERR <= 1'b0;
                            PRDATA  <= ((WAIT_LOAD == 5'd0) && !PWRITE) ? regs[idx] : '0;
                        end
                    end
                end

                ACCESS: begin
                    if (!access) begin
                        // Initiator abandoned the transfer: drop it silently
                        state   <= IDLE;
                        wcnt    <= '0;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else if (PREADY) begin
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                        if (acc_write && !acc_err) begin
                            regs[acc_idx] <= acc_wdata;
                            reg_wr        <= 1'b1;
                            reg_widx      <= acc_idx;
                            reg_wdata     <= acc_wdata;
                        end
                    end else begin
                        // Still waiting: PREADY rises as the count reaches zero
                        wcnt <= wcnt - 5'd1;
                        if (wcnt == 5'd1) begin
                            PREADY <= 1'b1;
                            PRDATA <= acc_write ? '0 : acc_rdata;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_completer.sv
// tb/tb_apb_reg_completer.sv - directed scoreboard bench for apb_reg_completer
module tb_apb_reg_completer;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel0, psel2, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2;
    logic        reg_wr0, reg_wr2;
    logic [7:0]  reg_widx0, reg_widx2;
    logic [31:0] reg_wdata0, reg_wdata2;
    logic        core_we;
    logic [7:0]  core_idx;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata0, core_rdata2;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt0  = 0;
    int wr_cnt2  = 0;

    logic [31:0] exp_rd_q[$];
    int          exp_cyc_q[$];

    always #5 clk = ~clk;

    apb_reg_completer #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2),
        .PSLVERR(pslverr2), .reg_wr(reg_wr2), .reg_widx(reg_widx2),
        .reg_wdata(reg_wdata2), .core_we(core_we), .core_idx(core_idx),
        .core_wdata(core_wdata), .core_rdata(core_rdata2)
    );

    apb_reg_completer #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .reg_wr(reg_wr0), .reg_widx(reg_widx0),
        .reg_wdata(reg_wdata0), .core_we(core_we), .core_idx(core_idx),
        .core_wdata(core_wdata), .core_rdata(core_rdata0)
    );

    always @(posedge clk) begin
        if (reg_wr0) wr_cnt0 <= wr_cnt0 + 1;
        if (reg_wr2) wr_cnt2 <= wr_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; core_we = 1'b0;
    endtask

    task automatic cwrite(input logic [7:0] i, input logic [31:0] d);
        @(negedge clk);
        core_we = 1'b1; core_idx = i; core_wdata = d;
        @(negedge clk);
        core_we = 1'b0;
    endtask

    task automatic cread2(input logic [7:0] i, output logic [31:0] d);
        core_idx = i;
        #1;
        d = core_rdata2;
    endtask

    task automatic xfer(input logic use0, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int limit,
                        input logic cw, input logic [7:0] cidx, input logic [31:0] cdat,
                        output int cyc, output logic [31:0] rd, output logic err);
        int k;
        @(negedge clk);
        psel0 = use0; psel2 = !use0; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d;
        cyc = 0; rd = '0; err = 1'b0; k = 0;
        while (cyc == 0 && k < limit) begin
            @(negedge clk);
            penable = 1'b1;
            k++;
            if (use0 ? pready0 : pready2) begin
                cyc = k;
                rd  = use0 ? prdata0 : prdata2;
                err = use0 ? pslverr0 : pslverr2;
                if (cw) begin
                    core_we = 1'b1; core_idx = cidx; core_wdata = cdat;
                end
            end
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd, v;
        logic        err;
        int          wc;

        rst = 1'b1; psel0 = 0; psel2 = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; core_we = 0; core_idx = '0; core_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset with registers pre-written
        cwrite(8'd0, 32'h11);
        cwrite(8'd254, 32'h22);
        cread2(8'd0, v);   check("prewrite_idx0", v, 32'h11);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rst_pready", {31'b0, pready2}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr2}, 32'd0);
        check("rst_prdata", prdata2, 32'd0);
        check("rst_reg_wr", {31'b0, reg_wr2}, 32'd0);
        check("rst_reg_widx", {24'b0, reg_widx2}, 32'd0);
        check("rst_reg_wdata", reg_wdata2, 32'd0);
        cread2(8'd0, v);   check("rst_core_idx0", v, 32'd0);
        cread2(8'd254, v); check("rst_core_idx254", v, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Two wait states: write then read back
        xfer(0, 1, 32'h8c000010, 32'hCAFEF00D, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle();
        check("ws2_wr_cycle", 32'(cyc), 32'd3);
        check("ws2_wr_err", {31'b0, err}, 32'd0);
        check("ws2_reg_wr", {31'b0, reg_wr2}, 32'd1);
        check("ws2_reg_widx", {24'b0, reg_widx2}, 32'd4);
        check("ws2_reg_wdata", reg_wdata2, 32'hCAFEF00D);
        check("ws2_pready_drop", {31'b0, pready2}, 32'd0);
        idle();
        check("ws2_reg_wr_pulse", {31'b0, reg_wr2}, 32'd0);
        cread2(8'd4, v); check("ws2_core_idx4", v, 32'hCAFEF00D);
        exp_rd_q.push_back(32'hCAFEF00D); exp_cyc_q.push_back(3);
        xfer(0, 0, 32'h8c000010, 32'd0, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle();
        check("ws2_rd_data", rd, exp_rd_q.pop_front());
        check("ws2_rd_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        check("ws2_rd_prdata_drop", prdata2, 32'd0);

        // Zero wait states: last register, then one past the window
        cwrite(8'd254, 32'hA5A50254);
        exp_rd_q.push_back(32'hA5A50254); exp_cyc_q.push_back(1);
        xfer(1, 0, 32'h8c0003f8, 32'd0, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle();
        check("ws0_rd_data", rd, exp_rd_q.pop_front());
        check("ws0_rd_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        check("ws0_rd_err", {31'b0, err}, 32'd0);
        wc = wr_cnt0;
        xfer(1, 1, 32'h8c0003fc, 32'h5555, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle(); idle();
        check("ws0_past_end_timeout", 32'(cyc), 32'd0);
        check("ws0_past_end_no_wr", 32'(wr_cnt0), 32'(wc));

        // Below the window
        wc = wr_cnt2;
        xfer(0, 1, 32'h8bffff00, 32'h7777, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle(); idle();
        check("below_timeout", 32'(cyc), 32'd0);
        check("below_no_wr", 32'(wr_cnt2), 32'(wc));
        cread2(8'd4, v);   check("below_idx4_kept", v, 32'hCAFEF00D);
        cread2(8'd192, v); check("below_idx192_kept", v, 32'd0);

        // Misaligned write
        cwrite(8'd0, 32'h1234);
        wc = wr_cnt2;
        xfer(0, 1, 32'h8c000002, 32'hDEAD, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle(); idle();
        check("mis_cycle", 32'(cyc), 32'd1);
        check("mis_pslverr", {31'b0, err}, 32'd1);
        check("mis_prdata", rd, 32'd0);
        check("mis_no_wr", 32'(wr_cnt2), 32'(wc));
        cread2(8'd0, v); check("mis_idx0_kept", v, 32'h1234);

        // Core and APB writes in the same cycle
        xfer(0, 1, 32'h8c000010, 32'h2, 32, 1, 8'd4, 32'h1, cyc, rd, err);
        idle();
        cread2(8'd4, v); check("coll_same_idx", v, 32'h2);
        xfer(0, 1, 32'h8c000018, 32'h66, 32, 1, 8'd7, 32'h77, cyc, rd, err);
        idle();
        cread2(8'd6, v); check("coll_apb_idx6", v, 32'h66);
        cread2(8'd7, v); check("coll_core_idx7", v, 32'h77);

        // Out-of-range core write is ignored
        cwrite(8'd255, 32'hFFFF);
        cread2(8'd255, v); check("core_idx255", v, 32'd0);

        // Reset during wait states drops the write
        cwrite(8'd8, 32'h99);
        wc = wr_cnt2;
        xfer(0, 1, 32'h8c000020, 32'h88, 1, 0, 8'd0, 32'd0, cyc, rd, err);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel2 = 1'b0; penable = 1'b0;
        check("rstmid_pready", {31'b0, pready2}, 32'd0);
        idle();
        check("rstmid_no_wr", 32'(wr_cnt2), 32'(wc));
        cread2(8'd8, v); check("rstmid_idx8", v, 32'd0);

        // Back-to-back write then read of another index
        cwrite(8'd8, 32'h88);
        exp_rd_q.push_back(32'h88); exp_cyc_q.push_back(3);
        xfer(0, 1, 32'h8c000024, 32'h9, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        check("b2b_wr_cycle", 32'(cyc), 32'd3);
        xfer(0, 0, 32'h8c000020, 32'd0, 32, 0, 8'd0, 32'd0, cyc, rd, err);
        idle();
        check("b2b_rd_data", rd, exp_rd_q.pop_front());
        check("b2b_rd_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        cread2(8'd9, v); check("b2b_idx9", v, 32'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
